// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM arbiter: FSM states, port ids, bus widths and the latched access.
// Pure declarations; no logic, no latency, no backpressure.
package sram_arb_pkg;

  localparam int SRAM_AW = 20;
  localparam int SRAM_DW = 16;

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  typedef enum logic {PORT_VID, PORT_DRW} port_t;

  typedef struct packed {
    port_t              port;
    logic               we;
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_DW-1:0] wdata;
    logic [1:0]         be;
  } acc_t;

endpackage

// File: rtl/sram_phy.sv
// SRAM pin stage: registers strobes/address/data-enable so pins change only on clock edges.
// Latency 1 cycle from *_d inputs to pins; no backpressure; reset forces strobes inactive at once.
module sram_phy
  import sram_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ce_n_d,
  input  logic               oe_n_d,
  input  logic               we_n_d,
  input  logic               ub_n_d,
  input  logic               lb_n_d,
  input  logic               dq_oe_d,
  input  logic [SRAM_AW-1:0] addr_d,
  input  logic [SRAM_DW-1:0] wdata_d,
  output logic [SRAM_DW-1:0] dq_in,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n,
  inout  wire  [SRAM_DW-1:0] sram_dq
);

  logic               dq_oe;
  logic [SRAM_DW-1:0] dq_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_ub_n <= 1'b1;
      sram_lb_n <= 1'b1;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
    end else begin
      sram_addr <= addr_d;
      sram_ce_n <= ce_n_d;
      sram_oe_n <= oe_n_d;
      sram_we_n <= we_n_d;
      sram_ub_n <= ub_n_d;
      sram_lb_n <= lb_n_d;
      dq_oe     <= dq_oe_d;
      dq_out    <= wdata_d;
    end
  end

  assign sram_dq = dq_oe ? dq_out : {SRAM_DW{1'bz}};
  assign dq_in   = sram_dq;

endmodule

// File: rtl/sram_arbiter.sv
// Video/draw arbiter for one async SRAM; access = IDLE + ACCESS_CYCLES + ACK, ack ACCESS_CYCLES+1 after grant.
// Requesters hold req until ack (video priority, draw forced after MAX_VID_RUN); SRAM_ARB_STATS_EN adds a draw stall counter.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int MAX_VID_RUN   = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               vid_req,
  input  logic [SRAM_AW-1:0] vid_addr,
  output logic               vid_ack,
  output logic [SRAM_DW-1:0] vid_rdata,
  input  logic               drw_req,
  input  logic               drw_we,
  input  logic [SRAM_AW-1:0] drw_addr,
  input  logic [SRAM_DW-1:0] drw_wdata,
  input  logic [1:0]         drw_be,
  output logic               drw_ack,
  output logic [SRAM_DW-1:0] drw_rdata,
`ifdef SRAM_ARB_STATS_EN
  input  logic               stats_clr,
  output logic [15:0]        draw_stall_cnt,
`endif
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  localparam int         RUN_W = $clog2(MAX_VID_RUN + 1);
  localparam logic [2:0] LAST  = 3'(ACCESS_CYCLES - 1);

  state_t             state, state_n;
  logic [2:0]         cyc, cyc_n;
  logic [RUN_W-1:0]   run_cnt, run_cnt_n;
  acc_t               acc, acc_n;
  logic               drw_win, last_cyc, in_acc_n, wr_n;
  logic [SRAM_DW-1:0] dq_in;

  always_comb begin
    state_n   = state;
    cyc_n     = cyc;
    run_cnt_n = run_cnt;
    acc_n     = acc;
    drw_win   = drw_req && (!vid_req || run_cnt == RUN_W'(MAX_VID_RUN));
    unique case (state)
      IDLE: begin
        if (vid_req || drw_req) begin
          state_n = ACCESS;
          cyc_n   = 3'd0;
          if (drw_win) begin
            acc_n     = '{port: PORT_DRW, we: drw_we, addr: drw_addr, wdata: drw_wdata, be: drw_be};
            run_cnt_n = '0;
          end else begin
            // video always reads both bytes; be=11 lets the byte strobes share one path
            acc_n     = '{port: PORT_VID, we: 1'b0, addr: vid_addr, wdata: {SRAM_DW{1'b0}}, be: 2'b11};
            run_cnt_n = drw_req ? run_cnt + RUN_W'(1) : '0;
          end
        end
      end
      ACCESS: begin
        if (cyc == LAST) state_n = ACK;
        else             cyc_n   = cyc + 3'd1;
      end
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign last_cyc = (state == ACCESS) && (cyc == LAST);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      cyc       <= 3'd0;
      run_cnt   <= '0;
      acc       <= '0;
      vid_ack   <= 1'b0;
      drw_ack   <= 1'b0;
      vid_rdata <= '0;
      drw_rdata <= '0;
    end else begin
      state   <= state_n;
      cyc     <= cyc_n;
      run_cnt <= run_cnt_n;
      acc     <= acc_n;
      vid_ack <= last_cyc && (acc.port == PORT_VID);
      drw_ack <= last_cyc && (acc.port == PORT_DRW);
      if (last_cyc && !acc.we) begin
        if (acc.port == PORT_VID) vid_rdata <= dq_in;
        else                      drw_rdata <= dq_in;
      end
    end
  end

  // Pins are registered, so drive the phy with what the next cycle needs.
  assign in_acc_n = (state_n == ACCESS);
  assign wr_n     = in_acc_n && acc_n.we;

  sram_phy u_phy (
    .clk       (Clk),
    .rst       (Reset),
    .ce_n_d    (!in_acc_n),
    .oe_n_d    (!(in_acc_n && !acc_n.we)),
    .we_n_d    (!(wr_n && cyc_n != 3'd0)),
    .ub_n_d    (!(in_acc_n && acc_n.be[1])),
    .lb_n_d    (!(in_acc_n && acc_n.be[0])),
    .dq_oe_d   (wr_n),
    .addr_d    (in_acc_n ? acc_n.addr : {SRAM_AW{1'b0}}),
    .wdata_d   (acc_n.wdata),
    .dq_in     (dq_in),
    .sram_addr (SRAM_ADDR),
    .sram_ce_n (SRAM_CE_N),
    .sram_oe_n (SRAM_OE_N),
    .sram_we_n (SRAM_WE_N),
    .sram_ub_n (SRAM_UB_N),
    .sram_lb_n (SRAM_LB_N),
    .sram_dq   (SRAM_DQ)
  );

`ifdef SRAM_ARB_STATS_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      draw_stall_cnt <= 16'd0;
    else if (stats_clr)
      draw_stall_cnt <= 16'd0;
    else if (drw_req && !drw_ack && draw_stall_cnt != 16'hFFFF)
      draw_stall_cnt <= draw_stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: cycle-level expectation queue plus directed scenarios.
module tb_sram_arbiter;

  localparam int AC  = 2;
  localparam int MVR = 8;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        vid_req = 1'b0;
  logic [19:0] vid_addr = '0;
  logic        vid_ack;
  logic [15:0] vid_rdata;
  logic        drw_req = 1'b0;
  logic        drw_we = 1'b0;
  logic [19:0] drw_addr = '0;
  logic [15:0] drw_wdata = '0;
  logic [1:0]  drw_be = 2'b11;
  logic        drw_ack;
  logic [15:0] drw_rdata;
  logic [19:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
`ifdef SRAM_ARB_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] draw_stall_cnt;
`endif

  always #5 Clk = ~Clk;

  sram_arbiter #(.ACCESS_CYCLES(AC), .MAX_VID_RUN(MVR)) dut (
    .Clk(Clk), .Reset(Reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .drw_req(drw_req), .drw_we(drw_we), .drw_addr(drw_addr), .drw_wdata(drw_wdata),
    .drw_be(drw_be), .drw_ack(drw_ack), .drw_rdata(drw_rdata),
`ifdef SRAM_ARB_STATS_EN
    .stats_clr(stats_clr), .draw_stall_cnt(draw_stall_cnt),
`endif
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
  );

  wire dut_dq_oe = dut.u_phy.dq_oe;

  // ---------------- SRAM device model ----------------
  logic [15:0] sram_mem [logic [19:0]];
  logic [15:0] ref_mem  [logic [19:0]];
  logic [15:0] sram_rd = '0;
  logic [15:0] sram_w;
  logic        sram_oe;

  function automatic logic [15:0] dflt(input logic [19:0] a);
    return a[15:0] ^ 16'hC0DE;
  endfunction
  function automatic logic [15:0] sram_get(input logic [19:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : dflt(a);
  endfunction
  function automatic logic [15:0] ref_get(input logic [19:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  assign sram_oe = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
  assign SRAM_DQ = sram_oe ? sram_rd : 16'hzzzz;

  always @(negedge Clk) begin
    sram_rd = sram_get(SRAM_ADDR);
    if (!SRAM_CE_N && !SRAM_WE_N) begin
      sram_w = sram_get(SRAM_ADDR);
      if (!SRAM_UB_N) sram_w[15:8] = SRAM_DQ[15:8];
      if (!SRAM_LB_N) sram_w[7:0]  = SRAM_DQ[7:0];
      sram_mem[SRAM_ADDR] = sram_w;
    end
  end

  // ---------------- Behavioural model: one record per expected cycle ----------------
  // sig = {CE_N, OE_N, WE_N, UB_N, LB_N, dq_drive, vid_ack, drw_ack}
  typedef struct {
    logic [7:0]  sig;
    logic [19:0] addr;
    logic [15:0] wd;
    logic [1:0]  be;
    bit          is_acc, wr, upd_v, upd_d;
    logic [15:0] rd;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  bit          was_idle;
  bit          ack_log[$];
  int          run = 0;
  logic [15:0] exp_vrd = '0, exp_drd = '0, ref_w;
  int          n_cmp = 0, n_fail = 0;
  int          n_oe_lo = 0, n_we_lo = 0, n_dq_drv = 0, n_ub_lo = 0, n_lb_lo = 0, n_clash = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: no ack within cycle budget at t=%0t", nm, $time);
  endtask

  function automatic exp_t idle_rec();
    exp_t r;
    r.sig = 8'b1111_1000; r.addr = '0; r.wd = '0; r.be = '0;
    r.is_acc = 0; r.wr = 0; r.upd_v = 0; r.upd_d = 0; r.rd = '0;
    return r;
  endfunction

  task automatic predict();
    exp_t        r;
    bit          dw, we;
    logic [19:0] a;
    logic [1:0]  be;
    dw = drw_req && (!vid_req || run == MVR);
    if (dw || !drw_req) run = 0; else run++;
    we = dw ? drw_we : 1'b0;
    a  = dw ? drw_addr : vid_addr;
    be = dw ? drw_be : 2'b11;
    for (int k = 0; k < AC; k++) begin
      r = idle_rec();
      r.sig = {1'b0, we, !(we && k > 0), !be[1], !be[0], we, 2'b00};
      r.is_acc = 1; r.addr = a; r.wd = drw_wdata;
      q.push_back(r);
    end
    r = idle_rec();
    r.sig = {5'b11111, 1'b0, !dw, dw};
    r.addr = a; r.wd = drw_wdata; r.be = be; r.wr = we;
    r.upd_v = !dw; r.upd_d = dw && !we; r.rd = ref_get(a);
    q.push_back(r);
  endtask

  always @(negedge Clk) begin
    was_idle = 0;
    if (Reset) begin
      q.delete(); run = 0; exp_vrd = '0; exp_drd = '0; cur = idle_rec();
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else begin
      cur = idle_rec(); was_idle = 1;
    end
    if (cur.wr) begin
      ref_w = ref_get(cur.addr);
      if (cur.be[1]) ref_w[15:8] = cur.wd[15:8];
      if (cur.be[0]) ref_w[7:0]  = cur.wd[7:0];
      ref_mem[cur.addr] = ref_w;
    end
    if (cur.upd_v) exp_vrd = cur.rd;
    if (cur.upd_d) exp_drd = cur.rd;
    check("cycle_strobes_acks",
          {24'd0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, dut_dq_oe, vid_ack, drw_ack},
          {24'd0, cur.sig});
    check("cycle_vid_rdata", vid_rdata, exp_vrd);
    check("cycle_drw_rdata", drw_rdata, exp_drd);
    if (cur.is_acc) check("cycle_addr", SRAM_ADDR, cur.addr);
    if (cur.sig[2]) check("cycle_dq_wdata", SRAM_DQ, cur.wd);
    if (!SRAM_OE_N) n_oe_lo++;
    if (!SRAM_WE_N) n_we_lo++;
    if (!SRAM_UB_N) n_ub_lo++;
    if (!SRAM_LB_N) n_lb_lo++;
    if (dut_dq_oe) n_dq_drv++;
    if (dut_dq_oe && !SRAM_OE_N) n_clash++;
    if (vid_ack) ack_log.push_back(1'b0);
    if (drw_ack) ack_log.push_back(1'b1);
    if (was_idle && (vid_req || drw_req)) predict();
  end

  // ---------------- Stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic vid_rd(input logic [19:0] a, output int lat);
    vid_addr = a; vid_req = 1'b1; lat = 0;
    do begin @(posedge Clk); #1; lat++; end while (!vid_ack && lat < 64);
    if (!vid_ack) timeout("vid_rd");
    vid_req = 1'b0;
  endtask

  task automatic drw_op(input logic we, input logic [19:0] a, input logic [15:0] wd,
                        input logic [1:0] be, output int lat);
    drw_we = we; drw_addr = a; drw_wdata = wd; drw_be = be; drw_req = 1'b1; lat = 0;
    do begin @(posedge Clk); #1; lat++; end while (!drw_ack && lat < 64);
    if (!drw_ack) timeout("drw_op");
    drw_req = 1'b0;
  endtask

  initial begin
    int lat, dcnt, k, vcnt, s_oe, s_we, s_dq, s_ub, s_lb, s_clash;

    // reset state
    repeat (3) @(posedge Clk);
    #1;
    check("rst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 5'b11111);
    check("rst_addr", SRAM_ADDR, 20'h0);
    check("rst_dq_oe", dut_dq_oe, 1'b0);
    check("rst_acks", {vid_ack, drw_ack}, 2'b00);
    check("rst_rdata", {vid_rdata, drw_rdata}, 32'h0);
    Reset = 1'b0;
    idle(1);

    // video read, AC=2
    sram_mem[20'h00100] = 16'hBEEF; ref_mem[20'h00100] = 16'hBEEF;
    s_oe = n_oe_lo;
    vid_rd(20'h00100, lat);
    check("vid_latency", lat, 3);
    check("vid_oe_cycles", n_oe_lo - s_oe, 2);
    check("vid_rdata_beef", vid_rdata, 16'hBEEF);
    idle(1);

    // draw write, low byte only
    sram_mem[20'h12345] = 16'h7700; ref_mem[20'h12345] = 16'h7700;
    s_we = n_we_lo; s_dq = n_dq_drv; s_ub = n_ub_lo; s_lb = n_lb_lo;
    drw_op(1'b1, 20'h12345, 16'hA5C3, 2'b01, lat);
    check("wr_latency", lat, 3);
    check("wr_we_cycles", n_we_lo - s_we, 1);
    check("wr_dq_cycles", n_dq_drv - s_dq, 2);
    check("wr_ub_cycles", n_ub_lo - s_ub, 0);
    check("wr_lb_cycles", n_lb_lo - s_lb, 2);
    check("wr_mem_low_byte", sram_get(20'h12345), 16'h77C3);
    idle(1);

    // both requesting continuously: 8 video then 1 draw
    ack_log.delete();
    vid_addr = 20'h00200; vid_req = 1'b1;
    drw_we = 1'b0; drw_addr = 20'h00300; drw_be = 2'b11; drw_req = 1'b1;
    dcnt = 0; k = 0;
    while (dcnt < 2 && k < 400) begin
      @(posedge Clk); #1; k++;
      if (drw_ack) dcnt++;
    end
    vid_req = 1'b0; drw_req = 1'b0;
    if (dcnt < 2) timeout("fair_run");
    @(negedge Clk); #1;
    check("fair_grant_count", ack_log.size(), 18);
    for (int i = 0; i < 18 && i < ack_log.size(); i++)
      check("fair_grant_seq", {31'd0, ack_log[i]}, {31'd0, (i % 9) == 8});
    idle(1);

    // back-to-back draw read then write
    sram_mem[20'h00010] = 16'h1234; ref_mem[20'h00010] = 16'h1234;
    s_clash = n_clash;
    drw_op(1'b0, 20'h00010, 16'h0000, 2'b11, lat);
    check("b2b_rdata", drw_rdata, 16'h1234);
    drw_op(1'b1, 20'h00011, 16'h4321, 2'b11, lat);
    check("b2b_gap_latency", lat, 4);
    check("b2b_no_clash", n_clash - s_clash, 0);
    check("b2b_mem", sram_get(20'h00011), 16'h4321);
    idle(1);

    // write with no byte enables
    sram_mem[20'h00040] = 16'h9999; ref_mem[20'h00040] = 16'h9999;
    s_ub = n_ub_lo; s_lb = n_lb_lo;
    drw_op(1'b1, 20'h00040, 16'h0000, 2'b00, lat);
    check("be0_latency", lat, 3);
    check("be0_strobes", (n_ub_lo - s_ub) + (n_lb_lo - s_lb), 0);
    check("be0_mem", sram_get(20'h00040), 16'h9999);
    idle(1);

    // request dropped before ack still completes
    drw_we = 1'b1; drw_addr = 20'h00050; drw_wdata = 16'hABCD; drw_be = 2'b11; drw_req = 1'b1;
    @(posedge Clk); #1;
    drw_req = 1'b0;
    k = 0;
    while (!drw_ack && k < 64) begin @(posedge Clk); #1; k++; end
    check("drop_ack_seen", drw_ack, 1'b1);
    check("drop_mem", sram_get(20'h00050), 16'hABCD);
    idle(1);

    // reset in cycle 1 of a write
    sram_mem[20'h00222] = 16'h0F0F; ref_mem[20'h00222] = 16'h0F0F;
    drw_we = 1'b1; drw_addr = 20'h00222; drw_wdata = 16'h1357; drw_be = 2'b11; drw_req = 1'b1;
    k = 0;
    do begin @(posedge Clk); #1; k++; end while (SRAM_WE_N && k < 64);
    if (SRAM_WE_N) timeout("rst_mid_wait_we");
    Reset = 1'b1;
    #1;
    check("rstmid_strobes", {SRAM_WE_N, SRAM_CE_N, SRAM_OE_N}, 3'b111);
    check("rstmid_dq_release", dut_dq_oe, 1'b0);
    @(posedge Clk); @(posedge Clk); #1;
    check("rstmid_no_ack", drw_ack, 1'b0);
    check("rstmid_mem_untouched", sram_get(20'h00222), 16'h0F0F);
    Reset = 1'b0;
    k = 0;
    while (!drw_ack && k < 64) begin @(posedge Clk); #1; k++; end
    if (!drw_ack) timeout("rstmid_reissue");
    drw_req = 1'b0;
    check("rstmid_reissue_mem", sram_get(20'h00222), 16'h1357);
    idle(1);

`ifdef SRAM_ARB_STATS_EN
    // draw waits behind three video reads
    stats_clr = 1'b1;
    idle(1);
    stats_clr = 1'b0;
    vid_addr = 20'h00060; vid_req = 1'b1;
    drw_we = 1'b0; drw_addr = 20'h00070; drw_be = 2'b11; drw_req = 1'b1;
    vcnt = 0; k = 0;
    while (drw_req && k < 100) begin
      @(posedge Clk); #1; k++;
      if (vid_ack) begin vcnt++; if (vcnt == 3) vid_req = 1'b0; end
      if (drw_ack) drw_req = 1'b0;
    end
    vid_req = 1'b0;
    if (drw_req) begin drw_req = 1'b0; timeout("stats_draw"); end
    idle(1);
    check("stats_stall_15", draw_stall_cnt, 16'd15);
    stats_clr = 1'b1;
    idle(1);
    stats_clr = 1'b0;
    check("stats_clr_zero", draw_stall_cnt, 16'd0);
    idle(1);
`endif

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
